// File: rtl/fetch_stage.sv
// RV32I fetch stage with IF/ID pipeline register, one-entry skid buffer and in-flight redirect handling.
// Define FETCH_STATS_EN to add the FetchCount/BubbleCount statistics outputs.

module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic [31:0] ImemRdata,
  input  logic        ImemValid,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
`ifdef FETCH_STATS_EN
  output logic        FetchBusy,
  output logic [31:0] FetchCount,
  output logic [31:0] BubbleCount
`else
  output logic        FetchBusy
`endif
);

  typedef enum logic [1:0] {S_RUN, S_HOLD, S_DROP} state_e;
  typedef enum logic [1:0] {IFID_HOLD, IFID_LOAD_MEM, IFID_LOAD_SKID, IFID_BUBBLE} ifid_op_e;

  state_e      state_q, state_d;
  ifid_op_e    ifid_op;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drop_addr_q, drop_addr_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcd_q, pcd_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        done;

  // The skid buffer is full exactly when the FSM sits in HOLD, so it needs no flag of its own.
  assign ImemReq   = rst_n & (state_q != S_HOLD);
  assign ImemAddr  = (state_q == S_DROP) ? drop_addr_q : pc_q;
  assign done      = ImemReq & ImemValid;
  assign FetchBusy = ImemReq & ~ImemValid;

  assign InstrD   = instr_q;
  assign PCD      = pcd_q;
  assign PCPlus4D = pc4_q;
  assign ValidD   = valid_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    pc_d         = pc_q;
    drop_addr_d  = drop_addr_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    ifid_op      = IFID_HOLD;

    if (PCSrcE) begin
      pc_d = PCTargetE;
      case (state_q)
        S_RUN: begin
          if (!done) begin
            drop_addr_d = pc_q;
            state_d     = S_DROP;
          end
        end
        S_HOLD:  state_d = S_RUN;
        S_DROP:  state_d = S_DROP;
        default: state_d = S_RUN;
      endcase
      if (!StallD) ifid_op = IFID_BUBBLE;
    end else begin
      case (state_q)
        S_RUN: begin
          if (done) begin
            pc_d = pc_q + 32'd4;
            if (StallD) begin
              skid_instr_d = ImemRdata;
              skid_pc_d    = pc_q;
              state_d      = S_HOLD;
            end else begin
              ifid_op = IFID_LOAD_MEM;
            end
          end else if (!StallD) begin
            ifid_op = IFID_BUBBLE;
          end
        end
        S_HOLD: begin
          // A flush without redirect leaves the skid entry parked for the next free cycle.
          if (!StallD && !FlushD) begin
            ifid_op = IFID_LOAD_SKID;
            state_d = S_RUN;
          end
        end
        S_DROP: begin
          if (done) state_d = S_RUN;
          if (!StallD) ifid_op = IFID_BUBBLE;
        end
        default: state_d = S_RUN;
      endcase
    end

    if (FlushD) ifid_op = IFID_BUBBLE;
  end

  always_comb begin
    instr_d = instr_q;
    pcd_d   = pcd_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    case (ifid_op)
      IFID_LOAD_MEM: begin
        instr_d = ImemRdata;
        pcd_d   = pc_q;
        pc4_d   = pc_q + 32'd4;
        valid_d = 1'b1;
      end
      IFID_LOAD_SKID: begin
        instr_d = skid_instr_q;
        pcd_d   = skid_pc_q;
        pc4_d   = skid_pc_q + 32'd4;
        valid_d = 1'b1;
      end
      IFID_BUBBLE: begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_RUN;
      pc_q         <= RESET_PC;
      drop_addr_q  <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      instr_q      <= NOP_INSTR;
      pcd_q        <= '0;
      pc4_q        <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_addr_q  <= drop_addr_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      instr_q      <= instr_d;
      pcd_q        <= pcd_d;
      pc4_q        <= pc4_d;
      valid_q      <= valid_d;
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count_q;
  logic [31:0] bubble_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count_q  <= '0;
      bubble_count_q <= '0;
    end else begin
      if (ifid_op == IFID_LOAD_MEM || ifid_op == IFID_LOAD_SKID)
        fetch_count_q <= fetch_count_q + 32'd1;
      if (ifid_op == IFID_BUBBLE)
        bubble_count_q <= bubble_count_q + 32'd1;
    end
  end

  assign FetchCount  = fetch_count_q;
  assign BubbleCount = bubble_count_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: delivered IF/ID entries must follow the PC stream from the latest redirect.
// Build with FETCH_STATS_EN to also check the statistics counters.

module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic [31:0] ImemRdata = '0;
  logic        ImemValid = 1'b0;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD, FetchBusy;
`ifdef FETCH_STATS_EN
  logic [31:0] FetchCount, BubbleCount;
`endif

  int tests = 0;
  int fails = 0;
  int deliveries = 0;
  int fixed_lat = 0;  // negative selects random latency 0..3

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] next_pc;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .StallD(StallD), .FlushD(FlushD), .PCSrcE(PCSrcE),
    .PCTargetE(PCTargetE), .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemRdata(ImemRdata),
    .ImemValid(ImemValid), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .ValidD(ValidD),
`ifdef FETCH_STATS_EN
    .FetchBusy(FetchBusy), .FetchCount(FetchCount), .BubbleCount(BubbleCount)
`else
    .FetchBusy(FetchBusy)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got no event expected one within the cycle budget (t=%0t)", name, $time);
  endtask

  // Expected stream: sequential PCs from the most recent reset/redirect target.
  function automatic void fill();
    while (exp_q.size() < 8) begin
      exp_q.push_back('{pc: next_pc, instr: mem_word(next_pc)});
      next_pc = next_pc + 32'd4;
    end
  endfunction

  function automatic void restart(input logic [31:0] target);
    exp_q.delete();
    next_pc = target;
    fill();
  endfunction

  // Instruction memory: latency chosen per request; data is garbage until valid.
  logic        pending = 1'b0;
  int          wait_left = 0;
  logic [31:0] pend_addr = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      ImemValid = 1'b0;
      pending   = 1'b0;
    end else if (ImemReq) begin
      if (!pending) begin
        pending   = 1'b1;
        pend_addr = ImemAddr;
        wait_left = (fixed_lat < 0) ? int'($urandom_range(0, 3)) : fixed_lat;
      end else begin
        check("addr_stable", ImemAddr, pend_addr);
      end
      if (wait_left == 0) begin
        ImemValid = 1'b1;
        ImemRdata = mem_word(ImemAddr);
        pending   = 1'b0;
      end else begin
        ImemValid = 1'b0;
        ImemRdata = $urandom;
        wait_left--;
      end
    end else begin
      ImemValid = 1'b0;
      pending   = 1'b0;
    end
  end

  // Monitor: classifies each edge by the inputs it saw and pops the scoreboard on deliveries.
  logic [31:0] p_instr = NOP, p_pcd = '0, p_pc4 = '0;
  logic        p_valid = 1'b0;
  logic [31:0] e_fetch = '0, e_bubble = '0;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      p_instr  = NOP;
      p_pcd    = '0;
      p_pc4    = '0;
      p_valid  = 1'b0;
      e_fetch  = '0;
      e_bubble = '0;
    end else begin
      if (FlushD || (!StallD && PCSrcE) || (!StallD && !ValidD)) begin
        check1("bubble_valid", ValidD, 1'b0);
        check("bubble_instr", InstrD, NOP);
        check("bubble_pcd", PCD, p_pcd);
        check("bubble_pc4", PCPlus4D, p_pc4);
        e_bubble = e_bubble + 32'd1;
      end else if (StallD) begin
        check1("hold_valid", ValidD, p_valid);
        check("hold_instr", InstrD, p_instr);
        check("hold_pcd", PCD, p_pcd);
        check("hold_pc4", PCPlus4D, p_pc4);
      end else if (exp_q.size() == 0) begin
        fail_now("scoreboard_underflow");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("deliver_pcd", PCD, e.pc);
        check("deliver_instr", InstrD, e.instr);
        check("deliver_pc4", PCPlus4D, e.pc + 32'd4);
        deliveries++;
        e_fetch = e_fetch + 32'd1;
      end
      check1("fetch_busy", FetchBusy, ImemReq & ~ImemValid);
`ifdef FETCH_STATS_EN
      check("fetch_count", FetchCount, e_fetch);
      check("bubble_count", BubbleCount, e_bubble);
`endif
      p_instr = InstrD;
      p_pcd   = PCD;
      p_pc4   = PCPlus4D;
      p_valid = ValidD;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
    fill();
  endtask

  task automatic wait_valid(input string name, input int budget);
    int k = 0;
    do begin
      cyc();
      k++;
    end while (!ValidD && k < budget);
    if (!ValidD) fail_now(name);
  endtask

  task automatic finish_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  initial begin
    #500000;
    fail_now("watchdog");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          vcnt, bcnt;
    logic [31:0] pcd_before, old_addr, target;

    rst_n = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
    restart(RESET_PC);
    repeat (2) @(posedge clk);
    #2;
    check1("rst_req", ImemReq, 1'b0);
    check1("rst_valid", ValidD, 1'b0);
    check("rst_instr", InstrD, NOP);
    check("rst_pcd", PCD, 32'h0);
    check("rst_pc4", PCPlus4D, 32'h0);
`ifdef FETCH_STATS_EN
    check("rst_fetch_count", FetchCount, 32'h0);
    check("rst_bubble_count", BubbleCount, 32'h0);
`endif
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Zero-wait memory: one instruction per cycle.
    wait_valid("p1_first_valid", 6);
    check("p1_first_pcd", PCD, RESET_PC);
    vcnt = 0;
    repeat (8) begin
      cyc();
      if (ValidD) vcnt++;
    end
    check("p1_throughput", 32'(vcnt), 32'd8);

    // Two-cycle latency: ValidD 0,0,1 and FetchBusy two cycles in three.
    fixed_lat = 2;
    wait_valid("p2_sync", 8);
    vcnt = 0;
    bcnt = 0;
    repeat (9) begin
      cyc();
      if (ValidD) vcnt++;
      if (FetchBusy) bcnt++;
    end
    check("p2_valid_count", 32'(vcnt), 32'd3);
    check("p2_busy_count", 32'(bcnt), 32'd6);

    // Stall while a fetch completes: skid holds it, no request in HOLD.
    fixed_lat = 0;
    wait_valid("p3_sync", 8);
    cyc();
    pcd_before = PCD;
    StallD = 1'b1;
    cyc();
    check1("p3_hold_noreq", ImemReq, 1'b0);
    cyc();
    cyc();
    check("p3_stalled_pcd", PCD, pcd_before);
    StallD = 1'b0;
    cyc();
    check1("p3_skid_valid", ValidD, 1'b1);
    check("p3_skid_pcd", PCD, pcd_before + 32'd4);
    cyc();
    check("p3_next_pcd", PCD, pcd_before + 32'd8);

    // Redirect while a request is outstanding: old address held, then target fetched.
    fixed_lat = 3;
    repeat (3) cyc();
    old_addr = ImemAddr;
    PCSrcE = 1'b1;
    FlushD = 1'b1;
    PCTargetE = 32'h0000_0100;
    restart(32'h0000_0100);
    cyc();
    PCSrcE = 1'b0;
    FlushD = 1'b0;
    for (int k = 0; k < 12 && ImemAddr == old_addr; k++) cyc();
    check("p4_next_addr", ImemAddr, 32'h0000_0100);
    wait_valid("p4_first_valid", 20);
    check("p4_first_pcd", PCD, 32'h0000_0100);

    // Flush beats stall.
    fixed_lat = 0;
    wait_valid("p5_sync", 10);
    StallD = 1'b1;
    FlushD = 1'b1;
    cyc();
    StallD = 1'b0;
    FlushD = 1'b0;
    check1("p5_flush_valid", ValidD, 1'b0);
    check("p5_flush_instr", InstrD, NOP);

    // Randomized traffic: latency, stalls, flushes and redirects (some across the wrap).
    fixed_lat = -1;
    for (int i = 0; i < 1500; i++) begin
      int r;
      StallD = ($urandom_range(0, 99) < 25);
      PCSrcE = 1'b0;
      FlushD = 1'b0;
      r = int'($urandom_range(0, 99));
      if (r < 5) begin
        target = $urandom;
        target[1:0] = 2'b00;
        if ($urandom_range(0, 3) == 0) target = 32'hFFFF_FFF4;
        PCSrcE = 1'b1;
        FlushD = ($urandom_range(0, 3) != 0);
        PCTargetE = target;
        restart(target);
      end else if (r < 10 && StallD) begin
        FlushD = 1'b1;
      end
      cyc();
    end
    StallD = 1'b0;
    FlushD = 1'b0;
    PCSrcE = 1'b0;

    // Asynchronous reset in the middle of a long wait.
    fixed_lat = 5;
    wait_valid("p7_sync", 20);
    StallD = 1'b1;
    cyc();
    cyc();
    check1("p7_pre_busy", FetchBusy, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check1("p7_rst_req", ImemReq, 1'b0);
    check1("p7_rst_valid", ValidD, 1'b0);
    check("p7_rst_instr", InstrD, NOP);
`ifdef FETCH_STATS_EN
    check("p7_rst_fetch_count", FetchCount, 32'h0);
    check("p7_rst_bubble_count", BubbleCount, 32'h0);
`endif
    StallD = 1'b0;
    fixed_lat = 1;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    restart(RESET_PC);
    cyc();
    check1("p7_req_after", ImemReq, 1'b1);
    check("p7_addr_after", ImemAddr, RESET_PC);
    wait_valid("p7_first_valid", 10);
    check("p7_first_pcd", PCD, RESET_PC);
    repeat (10) cyc();

    check1("progress", deliveries > 300, 1'b1);
    finish_run();
  end

endmodule
